// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous RAM between two clients.
// Every access is an issue phase followed, for reads, by a one-cycle capture phase.
module ram_arbiter #(
  parameter int AW = 4,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] din0,
  output logic          gnt0,
  output logic          rvalid0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] din1,
  output logic          gnt1,
  output logic          rvalid1,
  output logic [DW-1:0] rdata,
  output logic          busy,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ISSUE   = 2'd1;
  localparam logic [1:0] CAPTURE = 2'd2;

  logic [1:0]    state_reg, state_next;
  logic          last_grant_reg, last_grant_next;
  logic          win_reg, win_next;
  logic          win_we_reg, win_we_next;
  logic          gnt0_next, gnt1_next;
  logic          rvalid0_next, rvalid1_next;
  logic          ram_we_next;
  logic [AW-1:0] ram_addr_next;
  logic [DW-1:0] ram_din_next;
  logic [DW-1:0] rdata_next;
  logic          busy_next;
  logic          sel;

  always_comb begin
    state_next      = state_reg;
    last_grant_next = last_grant_reg;
    win_next        = win_reg;
    win_we_next     = win_we_reg;
    gnt0_next       = 1'b0;
    gnt1_next       = 1'b0;
    rvalid0_next    = 1'b0;
    rvalid1_next    = 1'b0;
    ram_we_next     = 1'b0;
    ram_addr_next   = ram_addr;
    ram_din_next    = ram_din;
    rdata_next      = rdata;
    sel             = 1'b0;

    case (state_reg)
      IDLE: begin
        if (req0 || req1) begin
          // On a tie the requester that did not win last time goes next.
          sel             = (req0 && req1) ? ~last_grant_reg : req1;
          ram_addr_next   = sel ? addr1 : addr0;
          ram_din_next    = sel ? din1 : din0;
          ram_we_next     = sel ? we1 : we0;
          gnt0_next       = ~sel;
          gnt1_next       = sel;
          last_grant_next = sel;
          win_next        = sel;
          win_we_next     = sel ? we1 : we0;
          state_next      = ISSUE;
        end
      end
      ISSUE: begin
        // The RAM performs the command at the edge that leaves this state.
        state_next = win_we_reg ? IDLE : CAPTURE;
      end
      CAPTURE: begin
        rdata_next   = ram_dout;
        rvalid0_next = ~win_reg;
        rvalid1_next = win_reg;
        state_next   = IDLE;
      end
      default: state_next = IDLE;
    endcase

    busy_next = (state_next != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      last_grant_reg <= 1'b1;
      win_reg        <= 1'b0;
      win_we_reg     <= 1'b0;
      gnt0           <= 1'b0;
      gnt1           <= 1'b0;
      rvalid0        <= 1'b0;
      rvalid1        <= 1'b0;
      ram_we         <= 1'b0;
      ram_addr       <= '0;
      ram_din        <= '0;
      rdata          <= '0;
      busy           <= 1'b0;
    end else begin
      state_reg      <= state_next;
      last_grant_reg <= last_grant_next;
      win_reg        <= win_next;
      win_we_reg     <= win_we_next;
      gnt0           <= gnt0_next;
      gnt1           <= gnt1_next;
      rvalid0        <= rvalid0_next;
      rvalid1        <= rvalid1_next;
      ram_we         <= ram_we_next;
      ram_addr       <= ram_addr_next;
      ram_din        <= ram_din_next;
      rdata          <= rdata_next;
      busy           <= busy_next;
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter: per-requester command queues, a queue-level
// round-robin reference model, and a monitor that checks grants and read returns.
module tb_ram_arbiter;

  typedef struct packed {
    logic       we;
    logic [3:0] addr;
    logic [7:0] data;
  } cmd_t;

  typedef struct packed {
    logic       id;
    logic       we;
    logic [3:0] addr;
    logic [7:0] data;
  } exp_t;

  typedef struct packed {
    logic       id;
    logic [7:0] data;
    int         cyc;
  } rd_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0, we0, req1, we1;
  logic [3:0] addr0, addr1;
  logic [7:0] din0, din1;
  logic       gnt0, gnt1, rvalid0, rvalid1, busy, ram_we;
  logic [7:0] rdata, ram_din, ram_dout;
  logic [3:0] ram_addr;

  always #5 clk = ~clk;

  ram_arbiter #(.AW(4), .DW(8)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .din0(din0), .gnt0(gnt0), .rvalid0(rvalid0),
    .req1(req1), .we1(we1), .addr1(addr1), .din1(din1), .gnt1(gnt1), .rvalid1(rvalid1),
    .rdata(rdata), .busy(busy),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
  );

  // Behavioural 16x8 RAM with registered read data.
  logic [7:0] ram_mem [16];
  initial for (int i = 0; i < 16; i++) ram_mem[i] = 8'h00;
  always @(posedge clk) begin
    if (ram_we) ram_mem[ram_addr] <= ram_din;
    ram_dout <= ram_mem[ram_addr];
  end

  cmd_t q0[$], q1[$], s0[$], s1[$];
  exp_t exp_q[$];
  rd_t  rd_q[$];
  logic [7:0] m_mem [16];
  logic       m_last;
  int checks = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
  endtask

  // Requester drivers: present the queue head, advance on gnt.
  initial begin
    req0 = 1'b0; we0 = 1'b0; addr0 = 4'd0; din0 = 8'd0;
    forever begin
      @(negedge clk);
      if (rst) begin
        q0.delete();
        req0 = 1'b0;
      end else begin
        if (gnt0 && q0.size() > 0) void'(q0.pop_front());
        if (q0.size() > 0) begin
          req0 = 1'b1; we0 = q0[0].we; addr0 = q0[0].addr; din0 = q0[0].data;
        end else req0 = 1'b0;
      end
    end
  end

  initial begin
    req1 = 1'b0; we1 = 1'b0; addr1 = 4'd0; din1 = 8'd0;
    forever begin
      @(negedge clk);
      if (rst) begin
        q1.delete();
        req1 = 1'b0;
      end else begin
        if (gnt1 && q1.size() > 0) void'(q1.pop_front());
        if (q1.size() > 0) begin
          req1 = 1'b1; we1 = q1[0].we; addr1 = q1[0].addr; din1 = q1[0].data;
        end else req1 = 1'b0;
      end
    end
  end

  // Monitor: every grant must match the next expected transaction; reads
  // must return exactly two cycles after their grant.
  initial begin
    int   cyc;
    logic [7:0] last_rd;
    exp_t e;
    rd_t  r;
    cyc = 0;
    last_rd = 8'h00;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        last_rd = 8'h00;
        continue;
      end
      if (gnt0 || gnt1) begin
        chk("gnt_onehot", 32'(gnt0 & gnt1), 32'd0);
        if (exp_q.size() == 0) chk("unexpected_gnt", 32'({gnt1, gnt0}), 32'd0);
        else begin
          e = exp_q.pop_front();
          chk("gnt_id", 32'(gnt1), 32'(e.id));
          chk("gnt_busy", 32'(busy), 32'd1);
          chk("ram_we", 32'(ram_we), 32'(e.we));
          chk("ram_addr", 32'(ram_addr), 32'(e.addr));
          if (e.we) chk("ram_din", 32'(ram_din), 32'(e.data));
          else begin
            r.id = e.id; r.data = e.data; r.cyc = cyc + 2;
            rd_q.push_back(r);
          end
        end
      end else begin
        chk("ram_we_quiet", 32'(ram_we), 32'd0);
      end
      if (rvalid0 || rvalid1) begin
        chk("rvalid_onehot", 32'(rvalid0 & rvalid1), 32'd0);
        if (rd_q.size() == 0) chk("unexpected_rvalid", 32'({rvalid1, rvalid0}), 32'd0);
        else begin
          r = rd_q.pop_front();
          chk("rvalid_id", 32'(rvalid1), 32'(r.id));
          chk("rvalid_cycle", 32'(cyc), 32'(r.cyc));
          chk("rdata", 32'(rdata), 32'(r.data));
        end
        last_rd = rdata;
      end else begin
        chk("rdata_hold", 32'(rdata), 32'(last_rd));
        if (rd_q.size() > 0 && rd_q[0].cyc < cyc) begin
          chk("missing_rvalid", 32'd0, 32'd1);
          void'(rd_q.pop_front());
        end
      end
    end
  end

  // Reference: alternate while both lists have work, otherwise drain the rest.
  task automatic issue_phase();
    int   i0, i1;
    logic w;
    cmd_t c;
    exp_t e;
    i0 = 0; i1 = 0;
    while (i0 < s0.size() || i1 < s1.size()) begin
      if (i0 < s0.size() && i1 < s1.size()) w = ~m_last;
      else w = (i0 < s0.size()) ? 1'b0 : 1'b1;
      if (w) begin c = s1[i1]; i1++; end
      else begin c = s0[i0]; i0++; end
      e.id = w; e.we = c.we; e.addr = c.addr; e.data = c.data;
      if (c.we) m_mem[c.addr] = c.data;
      else e.data = m_mem[c.addr];
      m_last = w;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #2;
    foreach (s0[k]) q0.push_back(s0[k]);
    foreach (s1[k]) q1.push_back(s1[k]);
    s0.delete();
    s1.delete();
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (n < 2000 && (q0.size() > 0 || q1.size() > 0 || exp_q.size() > 0 ||
                        rd_q.size() > 0 || busy)) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) begin
      chk("phase_timeout", 32'(n), 32'd0);
      exp_q.delete();
      rd_q.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3 rst = 1'b1;
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    m_last = 1'b1;
  endtask

  function automatic cmd_t mk(input logic we, input int addr, input int data);
    cmd_t c;
    c.we = we; c.addr = 4'(addr); c.data = 8'(data);
    return c;
  endfunction

  initial begin
    int k, n0, n1;
    rst = 1'b1;
    m_last = 1'b1;
    for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_ctrl", 32'({gnt0, gnt1, rvalid0, rvalid1, busy, ram_we}), 32'd0);
    chk("rst_ram_addr", 32'(ram_addr), 32'd0);
    chk("rst_ram_din", 32'(ram_din), 32'd0);
    chk("rst_rdata", 32'(rdata), 32'd0);
    #2 rst = 1'b0;

    repeat (10) begin
      @(negedge clk);
      chk("idle_quiet", 32'({gnt0, gnt1, rvalid0, rvalid1, busy, ram_we}), 32'd0);
    end

    // Single requester write then read.
    s0.push_back(mk(1'b1, 3, 8'hA5));
    s0.push_back(mk(1'b0, 3, 0));
    issue_phase();
    wait_done();

    // First tie after reset: requester 0 reads old data, then requester 1 writes.
    do_reset();
    s0.push_back(mk(1'b0, 5, 0));
    s0.push_back(mk(1'b0, 5, 0));
    s1.push_back(mk(1'b1, 5, 8'h3C));
    issue_phase();
    wait_done();

    // Continuous contention: eight writes then read-back.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) s0.push_back(mk(1'b1, i, 8'h10 + i));
      else s1.push_back(mk(1'b1, i, 8'h10 + i));
    end
    issue_phase();
    wait_done();
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) s0.push_back(mk(1'b0, i, 0));
      else s1.push_back(mk(1'b0, i, 0));
    end
    issue_phase();
    wait_done();

    // Boundary addresses.
    s0.push_back(mk(1'b1, 15, 8'hFF));
    s1.push_back(mk(1'b1, 0, 8'h01));
    issue_phase();
    wait_done();
    s0.push_back(mk(1'b0, 15, 0));
    s1.push_back(mk(1'b0, 0, 0));
    issue_phase();
    wait_done();

    // Reset during the issue cycle of a write: the write must not land.
    s0.push_back(mk(1'b1, 7, 8'h00));
    issue_phase();
    wait_done();
    @(posedge clk);
    #2;
    exp_q.push_back({1'b0, 1'b1, 4'd7, 8'h77});
    q0.push_back(mk(1'b1, 7, 8'h77));
    k = 0;
    while (k < 20 && !gnt0) begin
      @(negedge clk);
      k++;
    end
    chk("midrst_gnt_seen", 32'(gnt0), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("midrst_ram_we", 32'(ram_we), 32'd0);
    chk("midrst_idle", 32'({busy, gnt0, gnt1, rvalid0, rvalid1}), 32'd0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    m_last = 1'b1;
    repeat (3) @(negedge clk);
    chk("midrst_after", 32'({busy, gnt0, gnt1, rvalid0, rvalid1, ram_we}), 32'd0);
    s0.push_back(mk(1'b0, 7, 0));
    issue_phase();
    wait_done();

    // Randomized mixed traffic.
    for (int p = 0; p < 20; p++) begin
      n0 = $urandom_range(0, 5);
      n1 = $urandom_range(0, 5);
      for (int i = 0; i < n0; i++)
        s0.push_back(mk(1'($urandom_range(0, 1)), $urandom_range(0, 15), $urandom_range(0, 255)));
      for (int i = 0; i < n1; i++)
        s1.push_back(mk(1'($urandom_range(0, 1)), $urandom_range(0, 15), $urandom_range(0, 255)));
      issue_phase();
      wait_done();
      if ($urandom_range(0, 4) == 0) do_reset();
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Two-requester round-robin arbiter that shares one single-port synchronous RAM (16 x 8, write-enable, registered read data) between two clients.
- Sequences every access as issue/complete phases and drives the RAM's we/addr/din.
- Returns read data to the winning requester with a one-cycle valid pulse.
- Sits between two client engines and the RAM instance.

Parameters:
- AW, 4, RAM address width (2^AW locations)
- DW, 8, RAM data width

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  asynchronous, active-high reset
- req0  input  1  requester 0 access request
- we0  input  1  requester 0 write (1) / read (0)
- addr0  input  AW  requester 0 address
- din0  input  DW  requester 0 write data
- gnt0  output  1  requester 0 command accepted (1-cycle pulse)
- rvalid0  output  1  requester 0 read data valid (1-cycle pulse)
- req1, we1, addr1, din1, gnt1, rvalid1  as above, for requester 1
- rdata  output  DW  read data, shared; qualified by rvalid0/rvalid1
- busy  output  1  high whenever state is not IDLE
- ram_we  output  1  to RAM write enable
- ram_addr  output  AW  to RAM address
- ram_din  output  DW  to RAM write data
- ram_dout  input  DW  from RAM registered read data

Behaviour:
- Reset (async, immediate): state=IDLE; gnt0/1, rvalid0/1, ram_we, busy = 0; ram_addr, ram_din, rdata = 0; last_grant = 1, so requester 0 wins the first tie.
- All outputs are registered; none is combinational from req*.
- FSM states are IDLE, ISSUE and CAPTURE.
- IDLE: req0/req1 are sampled only in this state.
  - Neither requesting: stay in IDLE.
  - One requesting: select it.
  - Both requesting: select the requester that is not last_grant.
  - On selection:
    - ram_addr <= addrX, ram_din <= dinX, ram_we <= weX.
    - gntX <= 1, last_grant <= X.
    - Remember the winner's id and weX; go to ISSUE.
- ISSUE (one cycle): the RAM acts on the command at the closing edge.
  - At that edge: gntX <= 0, ram_we <= 0.
  - Write: go to IDLE (write committed at this edge).
  - Read: go to CAPTURE.
- CAPTURE (one cycle): at the closing edge, rdata <= ram_dout, rvalid(winner) <= 1, then go to IDLE.
- rvalid drops after one cycle. rdata holds its value until the next read capture.
- Latency, with edge E0 = request sampled in IDLE:
  - gnt high E0..E1.
  - Write: committed at E1; next grant possible at E2.
  - Read: rvalid and rdata valid E2..E3; next grant possible at E3.
- Requester protocol:
  - Hold req/we/addr/din stable until gnt is seen.
  - Deassert req in the cycle after gnt, or keep it high to post a new request.
  - Any req still high when the FSM returns to IDLE is treated as a new transaction.
- Inputs are ignored in ISSUE and CAPTURE; command fields are latched at E0.
- Fairness: under continuous dual requests, grants alternate 0,1,0,1.
- A lone requester may win repeatedly.
- last_grant updates only on a grant.
- Read-after-write to the same address by either requester returns the new data, because accesses are serialised.
- Address wrap is not applicable: addresses pass through unmodified, full AW width.
- Reset during ISSUE: ram_we clears asynchronously, so a pending write may be lost.
- Reset during CAPTURE: no rvalid is produced.
- In both cases the FSM returns to IDLE and no gnt or rvalid is generated for the aborted transaction.
- busy = (state != IDLE), registered together with the state.

Test Plan:
- Reset then idle: all outputs 0, busy 0 for 10 cycles with req0=req1=0.
- Write then read, single requester: req0 writes addr 3 <- 0xA5, then reads addr 3.
  - Required: gnt0 one cycle each time.
  - Required: rvalid0 pulses 2 cycles after the read is sampled, with rdata=0xA5.
  - Required: rvalid1 stays 0.
- Simultaneous first request: req0 read addr 5 and req1 write addr 5 <- 0x3C, both from IDLE after reset.
  - Required: requester 0 is granted first and its read returns the old content (0x00 after preloading 0x00).
  - Required: requester 1 is granted next.
  - Required: a subsequent read of addr 5 returns 0x3C.
- Continuous contention: req0 and req1 held high for 8 writes to addrs 0..7 with data 0x10+i.
  - Required: gnt sequence is 0,1,0,1,...
  - Required: each write lands at its own address; verify by read-back.
- Boundary address: write addr 15 <- 0xFF and addr 0 <- 0x01, read both.
  - Required: 0xFF and 0x01 returned, no aliasing.
- Mid-operation reset: assert rst during ISSUE of a write of addr 7 <- 0x77, with 0x00 preloaded.
  - Required: ram_we drops immediately and the FSM is IDLE after release.
  - Required: a later read of addr 7 returns 0x00, and no gnt or rvalid glitch occurs.
